// File: rtl/dec_4x16_bist_ctrl.sv
// ---------------------------------------------------------------------------
// dec_4x16_bist_ctrl
//
// Built-in self-test sequencer for a 4x16 decoder. A start request sweeps the
// 16 input codes onto the decoder inputs. Each code is held for SETTLE_CYC
// cycles plus one check cycle. The decoder output is then compared against
// the expected one-hot (or one-cold) word, and the failing codes are recorded.
//
// Parameters
//   SETTLE_CYC  cycles each code is held before the output is sampled (1..15)
//   ACTIVE_LOW  0: expected word is one-hot high, 1: one-cold (inverted)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            sweep request, honoured only in IDLE or DONE
//   D_in[15:0]       decoder output under test
//   X, Y, Z, W       decoder inputs, code = {X,Y,Z,W} with X as MSB
//   busy             high while sweeping (SETTLE and CHECK)
//   done             high while results are held in DONE
//   pass             high in DONE when no code failed
//   fail_map[15:0]   bit i set when code i mismatched
//   fail_count[4:0]  number of failing codes, 0..16
//   first_fail_code  lowest failing code, 0 when none failed
// ---------------------------------------------------------------------------
module dec_4x16_bist_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] D_in,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        W,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_map,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // The settle counter counts down to zero, so it is loaded with one less
    // than the number of settle cycles wanted.
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] fail_map_q, fail_map_d;
    logic [4:0]  fail_count_q, fail_count_d;
    logic [3:0]  first_fail_q, first_fail_d;

    logic [15:0] one_hot;
    logic [15:0] expected;
    logic        mismatch;

    assign one_hot  = 16'h1 << code_q;
    assign expected = ACTIVE_LOW ? ~one_hot : one_hot;
    // Any number of wrong bits in one word counts as a single failing code.
    assign mismatch = |(D_in ^ expected);

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        fail_map_d   = fail_map_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_SETTLE;
                    code_d       = 4'd0;
                    cnt_d        = SETTLE_RELOAD;
                    fail_map_d   = 16'h0000;
                    fail_count_d = 5'd0;
                    first_fail_d = 4'd0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    fail_map_d[code_q] = 1'b1;
                    fail_count_d       = fail_count_q + 5'd1;
                    // The sweep runs upward, so the first failure seen is the lowest code.
                    if (fail_count_q == 5'd0) begin
                        first_fail_d = code_q;
                    end
                end
                if (code_q == 4'd15) begin
                    state_d = S_DONE;
                    code_d  = 4'd0;
                end else begin
                    state_d = S_SETTLE;
                    code_d  = code_q + 4'd1;
                    cnt_d   = SETTLE_RELOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            code_q       <= 4'd0;
            cnt_q        <= 4'd0;
            fail_map_q   <= 16'h0000;
            fail_count_q <= 5'd0;
            first_fail_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            fail_map_q   <= fail_map_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign {X, Y, Z, W}    = code_q;
    assign busy            = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done            = (state_q == S_DONE);
    assign pass            = (state_q == S_DONE) && (fail_count_q == 5'd0);
    assign fail_map        = fail_map_q;
    assign fail_count      = fail_count_q;
    assign first_fail_code = first_fail_q;

endmodule

// File: tb/tb_dec_4x16_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dec_4x16_bist_ctrl
//
// Two sequencers share the clock and reset:
//   dut0  SETTLE_CYC=2, ACTIVE_LOW=0  drives a one-hot decoder model with
//                                     stuck-at masks and per-code corruption
//   dut1  SETTLE_CYC=1, ACTIVE_LOW=1  drives a one-cold decoder model with
//                                     per-code corruption
// Expected results come from walking the 16 codes through the decoder fault
// model and counting the words that differ from the ideal decoder output.
// ---------------------------------------------------------------------------
module tb_dec_4x16_bist_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic [15:0] d_in0, d_in1;
    logic        x0, y0, z0, w0, busy0, done0, pass0;
    logic        x1, y1, z1, w1, busy1, done1, pass1;
    logic [15:0] fm0, fm1;
    logic [4:0]  fc0, fc1;
    logic [3:0]  ff0, ff1;
    logic [3:0]  code0, code1;

    // Decoder fault model: stuck-at masks plus an XOR corruption per code.
    logic [15:0] sa0_mask = 16'h0000;
    logic [15:0] sa1_mask = 16'h0000;
    logic [15:0] corrupt0 [16];
    logic [15:0] corrupt1 [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign code0 = {x0, y0, z0, w0};
    assign code1 = {x1, y1, z1, w1};

    always_comb begin
        d_in0 = (((16'h1 << code0) & ~sa0_mask) | sa1_mask) ^ corrupt0[code0];
    end

    always_comb begin
        d_in1 = ~(16'h1 << code1) ^ corrupt1[code1];
    end

    dec_4x16_bist_ctrl #(.SETTLE_CYC(S0), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .D_in(d_in0),
        .X(x0), .Y(y0), .Z(z0), .W(w0),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_map(fm0), .fail_count(fc0), .first_fail_code(ff0)
    );

    dec_4x16_bist_ctrl #(.SETTLE_CYC(S1), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .D_in(d_in1),
        .X(x1), .Y(y1), .Z(z1), .W(w1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_map(fm1), .fail_count(fc1), .first_fail_code(ff1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: push every code through the faulty decoder and compare with
    // the ideal decoder word.
    function automatic void ref_results(input bit which, output logic [15:0] fm,
                                        output logic [4:0] fc, output logic [3:0] ff);
        logic [15:0] good, seen;
        fm = '0;
        fc = '0;
        ff = '0;
        for (int c = 0; c < 16; c++) begin
            good = 16'h1 << c;
            if (which) good = ~good;
            seen = which ? (good ^ corrupt1[c])
                         : (((good & ~sa0_mask) | sa1_mask) ^ corrupt0[c]);
            if (seen != good) begin
                if (fc == 5'd0) ff = 4'(c);
                fm[c] = 1'b1;
                fc    = fc + 5'd1;
            end
        end
    endfunction

    task automatic clear_faults();
        sa0_mask = '0;
        sa1_mask = '0;
        for (int c = 0; c < 16; c++) begin
            corrupt0[c] = '0;
            corrupt1[c] = '0;
        end
    endtask

    // Returns at the falling edge just after the edge that sampled start.
    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        if (which) start1 = 1'b0; else start0 = 1'b0;
    endtask

    task automatic check_idle(input bit which, input string name);
        logic [30:0] got;
        got = which ? {code1, busy1, done1, pass1, fm1, fc1, ff1}
                    : {code0, busy0, done0, pass0, fm0, fc0, ff0};
        n_checks++;
        if (got !== 31'd0) begin
            n_fail++;
            $display("FAIL %s: {code,busy,done,pass,fail_map,fail_count,first} = %h, expected all zero",
                     name, got);
        end
    endtask

    // Called at the falling edge of sweep cycle 0. Checks the code sequence
    // every cycle, then the result registers once done rises.
    task automatic check_sweep(input bit which, input string name,
                               input int restart_cycle, input bit hold_end);
        int          per, total;
        logic [3:0]  c, eff;
        logic        b, d;
        logic [15:0] efm;
        logic [4:0]  efc;
        per   = which ? S1 + 1 : S0 + 1;
        total = 16 * per;
        ref_results(which, efm, efc, eff);
        for (int i = 0; i < total; i++) begin
            if (i > 0) @(negedge clk);
            if (i == restart_cycle) start0 = 1'b1;
            else if (i == restart_cycle + 1) start0 = 1'b0;
            if (hold_end && i == total - 1) begin
                if (which) start1 = 1'b1; else start0 = 1'b1;
            end
            c = which ? code1 : code0;
            b = which ? busy1 : busy0;
            d = which ? done1 : done0;
            n_checks++;
            if (c !== 4'(i / per) || b !== 1'b1 || d !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: code=%0d busy=%b done=%b, expected code=%0d busy=1 done=0",
                         name, i, c, b, d, i / per);
            end
        end
        @(negedge clk);
        d = which ? done1 : done0;
        b = which ? busy1 : busy0;
        c = which ? code1 : code0;
        n_checks++;
        if (d !== 1'b1 || b !== 1'b0 || c !== 4'd0) begin
            n_fail++;
            $display("FAIL %s done at cycle %0d: done=%b busy=%b code=%0d, expected 1 0 0",
                     name, total, d, b, c);
        end
        n_checks++;
        if ((which ? pass1 : pass0) !== (efc == 5'd0)) begin
            n_fail++;
            $display("FAIL %s pass: got %b expected %b", name, which ? pass1 : pass0, efc == 5'd0);
        end
        n_checks++;
        if ((which ? fm1 : fm0) !== efm) begin
            n_fail++;
            $display("FAIL %s fail_map: got %h expected %h", name, which ? fm1 : fm0, efm);
        end
        n_checks++;
        if ((which ? fc1 : fc0) !== efc) begin
            n_fail++;
            $display("FAIL %s fail_count: got %0d expected %0d", name, which ? fc1 : fc0, efc);
        end
        n_checks++;
        if ((which ? ff1 : ff0) !== eff) begin
            n_fail++;
            $display("FAIL %s first_fail_code: got %0d expected %0d", name, which ? ff1 : ff0, eff);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0, "reset dut0");
        check_idle(1, "reset dut1");
        start0 = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
        check_idle(0, "idle after reset");
    endtask

    task automatic test_fault_free();
        clear_faults();
        pulse_start(0);
        check_sweep(0, "fault_free", -1, 1'b0);
    endtask

    task automatic test_stuck0();
        clear_faults();
        sa0_mask = 16'h0100;
        pulse_start(0);
        check_sweep(0, "stuck0_d8", -1, 1'b0);
    endtask

    task automatic test_stuck1();
        clear_faults();
        sa1_mask = 16'h0100;
        pulse_start(0);
        check_sweep(0, "stuck1_d8", -1, 1'b0);
    endtask

    task automatic test_ignore_start();
        clear_faults();
        corrupt0[6] = 16'h8001;
        pulse_start(0);
        check_sweep(0, "ignore_start", 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        clear_faults();
        sa0_mask = 16'h0008;
        pulse_start(0);
        check_sweep(0, "b2b_first", -1, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        n_checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || code0 !== 4'd0 ||
            fm0 !== 16'h0000 || fc0 !== 5'd0 || ff0 !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b restart: done=%b busy=%b code=%0d fail_map=%h fail_count=%0d first=%0d, expected 0 1 0 0000 0 0",
                     done0, busy0, code0, fm0, fc0, ff0);
        end
        check_sweep(0, "b2b_second", -1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            clear_faults();
            for (int c = 0; c < 16; c++) begin
                corrupt0[c] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            end
            if ($urandom_range(0, 2) == 0) sa0_mask = 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) sa1_mask = 16'(1 << $urandom_range(0, 15));
            pulse_start(0);
            check_sweep(0, "random", -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_faults();
        corrupt0[1] = 16'h0004;
        pulse_start(0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (code0 == 4'd5) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid: code never reached 5 within 60 cycles, last code=%0d", code0);
        end
        #1 rst_n = 1'b0;
        #1 check_idle(0, "reset_mid immediate");
        @(negedge clk);
        rst_n = 1'b1;
        clear_faults();
        pulse_start(0);
        check_sweep(0, "after_reset_mid", -1, 1'b0);
    endtask

    task automatic test_active_low();
        clear_faults();
        pulse_start(1);
        check_sweep(1, "active_low_clean", -1, 1'b0);
        for (int c = 0; c < 16; c++) begin
            corrupt1[c] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
        end
        corrupt1[$urandom_range(0, 15)] = 16'h0010;
        pulse_start(1);
        check_sweep(1, "active_low_random", -1, 1'b0);
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_fault_free();
        test_stuck0();
        test_stuck1();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_active_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
